// File: rtl/multicycle_control.sv
// Control FSM for the multicycle RISC-V datapath: sequences fetch/decode/execute/memory/write-back
// and stretches every memory access by MEM_WAIT cycles.
module multicycle_control #(
  parameter int unsigned MEM_WAIT = 0,
  parameter int unsigned ALU_OP_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic [6:0]          funct7,
  input  logic                alu_zero,
  output logic                pc_write,
  output logic                pc_src,
  output logic                ir_write,
  output logic                old_pc_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                load_a,
  output logic                load_b,
  output logic                load_alu_out,
  output logic                load_mdr,
  output logic [1:0]          alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                reg_write,
  output logic [1:0]          wb_sel,
  output logic                illegal,
  output logic [3:0]          state_out
);

  localparam int unsigned cntW = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
  localparam logic [cntW-1:0] lastCnt = cntW'(MEM_WAIT);

  localparam logic [2:0] opPass  = 3'd0;
  localparam logic [2:0] opAdd   = 3'd1;
  localparam logic [2:0] opSub   = 3'd2;
  localparam logic [2:0] opAnd   = 3'd3;
  localparam logic [2:0] opOr    = 3'd4;
  localparam logic [2:0] opSlt   = 3'd5;
  localparam logic [2:0] opPassB = 3'd6;

  typedef enum logic [3:0] {
    StReset  = 4'd0,
    StFetch  = 4'd1,
    StDecode = 4'd2,
    StExecR  = 4'd3,
    StExecI  = 4'd4,
    StAddr   = 4'd5,
    StMemLd  = 4'd6,
    StLdWb   = 4'd7,
    StMemSt  = 4'd8,
    StAluWb  = 4'd9,
    StBranch = 4'd10,
    StLui    = 4'd11,
    StJal    = 4'd12,
    StHalt   = 4'd13
  } stateT;

  stateT           stateQ, stateD;
  logic [cntW-1:0] cntQ, cntD;
  logic            waitState, lastCyc;
  logic [2:0]      rOp;
  logic            rLegal;
  logic [2:0]      aluOp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ <= StReset;
      cntQ   <= '0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
    end
  end

  assign waitState = (stateQ == StFetch) || (stateQ == StMemLd) || (stateQ == StMemSt);
  assign lastCyc   = (cntQ == lastCnt);
  // Counter is zero outside the wait states, so it is already clear on entry to each of them.
  assign cntD      = (waitState && !lastCyc) ? cntQ + 1'b1 : '0;

  always_comb begin
    rOp    = opPass;
    rLegal = 1'b1;
    case ({funct7, funct3})
      10'b0000000_000: rOp = opAdd;
      10'b0100000_000: rOp = opSub;
      10'b0000000_111: rOp = opAnd;
      10'b0000000_110: rOp = opOr;
      10'b0000000_010: rOp = opSlt;
      default:         rLegal = 1'b0;
    endcase
  end

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StReset:  stateD = StFetch;
      StFetch:  if (lastCyc) stateD = StDecode;
      StDecode: begin
        case (opcode)
          7'b0110011:             stateD = StExecR;
          7'b0010011:             stateD = (funct3 == 3'b000) ? StExecI : StHalt;
          7'b0000011, 7'b0100011: stateD = (funct3 == 3'b010) ? StAddr : StHalt;
          7'b1100011:             stateD = (funct3[2:1] == 2'b00) ? StBranch : StHalt;
          7'b0110111:             stateD = StLui;
          7'b1101111:             stateD = StJal;
          default:                stateD = StHalt;
        endcase
      end
      StExecR:  stateD = rLegal ? StAluWb : StHalt;
      StExecI:  stateD = StAluWb;
      StLui:    stateD = StAluWb;
      StAluWb:  stateD = StFetch;
      StAddr:   stateD = (opcode == 7'b0000011) ? StMemLd : StMemSt;
      StMemLd:  if (lastCyc) stateD = StLdWb;
      StLdWb:   stateD = StFetch;
      StMemSt:  if (lastCyc) stateD = StFetch;
      StBranch: stateD = StFetch;
      StJal:    stateD = StFetch;
      StHalt:   stateD = StHalt;
      default:  stateD = StHalt;
    endcase
  end

  always_comb begin
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    ir_write     = 1'b0;
    old_pc_write = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    load_a       = 1'b0;
    load_b       = 1'b0;
    load_alu_out = 1'b0;
    load_mdr     = 1'b0;
    alu_src_a    = 2'd0;
    alu_src_b    = 2'd0;
    aluOp        = opPass;
    reg_write    = 1'b0;
    wb_sel       = 2'd0;
    illegal      = 1'b0;
    unique case (stateQ)
      StFetch: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        aluOp     = opAdd;
        if (lastCyc) begin
          ir_write     = 1'b1;
          old_pc_write = 1'b1;
          pc_write     = 1'b1;
        end
      end
      StDecode: begin
        load_a       = 1'b1;
        load_b       = 1'b1;
        load_alu_out = 1'b1;
        alu_src_a    = 2'd1;
        alu_src_b    = 2'd2;
        aluOp        = opAdd;
      end
      StExecR: begin
        alu_src_a    = 2'd2;
        load_alu_out = rLegal;
        aluOp        = rOp;
      end
      StExecI, StAddr: begin
        alu_src_a    = 2'd2;
        alu_src_b    = 2'd2;
        aluOp        = opAdd;
        load_alu_out = 1'b1;
      end
      StLui: begin
        alu_src_b    = 2'd2;
        aluOp        = opPassB;
        load_alu_out = 1'b1;
      end
      StAluWb: reg_write = 1'b1;
      StMemLd: begin
        mem_read = 1'b1;
        load_mdr = lastCyc;
      end
      StLdWb: begin
        reg_write = 1'b1;
        wb_sel    = 2'd1;
      end
      StMemSt: mem_write = 1'b1;
      StBranch: begin
        alu_src_a = 2'd2;
        aluOp     = opSub;
        pc_src    = 1'b1;
        pc_write  = (funct3 == 3'b000) ? alu_zero : !alu_zero;
      end
      StJal: begin
        reg_write = 1'b1;
        wb_sel    = 2'd2;
        pc_write  = 1'b1;
        pc_src    = 1'b1;
      end
      StHalt:  illegal = 1'b1;
      default: ;
    endcase
  end

  assign alu_op    = ALU_OP_W'(aluOp);
  assign state_out = stateQ;

endmodule
